// File: rtl/filterbank_pkg.sv
// filterbank_pkg: shared sizes, scheduler state type and output saturation.
package filterbank_pkg;

   localparam int FILTERS  = 9;
   localparam int SECTIONS = 2;
   localparam int BAND_W   = $clog2(FILTERS);
   localparam int SEC_W    = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
   localparam int ACC_W    = 32 + $clog2(FILTERS) + 1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } sched_state_t;

   localparam logic signed [ACC_W-1:0] ACC_MAX =
      {{(ACC_W-32){1'b0}}, 32'h7fff_ffff};
   localparam logic signed [ACC_W-1:0] ACC_MIN =
      {{(ACC_W-32){1'b1}}, 32'h8000_0000};

   function automatic logic signed [31:0] sat32(
      input logic signed [ACC_W-1:0] acc
   );
      if (acc > ACC_MAX)
         return 32'sh7fff_ffff;
      else if (acc < ACC_MIN)
         return 32'sh8000_0000;
      else
         return acc[31:0];
   endfunction

endpackage

// File: rtl/filterbank_scheduler_if.sv
// filterbank_scheduler_if: request/result bus to the shared biquad MAC.
interface filterbank_scheduler_if;
   import filterbank_pkg::*;

   logic               mac_req_out;
   logic [BAND_W-1:0]  mac_band_out;
   logic [SEC_W-1:0]   mac_section_out;
   logic signed [31:0] mac_sample_out;
   logic               mac_ready_in;
   logic               mac_valid_in;
   logic signed [31:0] mac_result_in;

   modport master (
      output mac_req_out,
      output mac_band_out,
      output mac_section_out,
      output mac_sample_out,
      input  mac_ready_in,
      input  mac_valid_in,
      input  mac_result_in
   );

   modport slave (
      input  mac_req_out,
      input  mac_band_out,
      input  mac_section_out,
      input  mac_sample_out,
      output mac_ready_in,
      output mac_valid_in,
      output mac_result_in
   );

endinterface

// File: rtl/sample_slot.sv
// sample_slot: one-entry input holding buffer with sticky drop flag.
module sample_slot (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               push,
   input  logic signed [31:0] data,
   input  logic               pop,
   output logic               full,
   output logic signed [31:0] q,
   output logic               ready,
   output logic               overflow
);

   assign ready = !full || pop;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         full     <= 1'b0;
         q        <= '0;
         overflow <= 1'b0;
      end else begin
         if (push && ready) begin
            full <= 1'b1;
            q    <= data;
         end else if (pop) begin
            full <= 1'b0;
         end
         if (push && !ready)
            overflow <= 1'b1;
      end
   end

endmodule

// File: rtl/filterbank_scheduler.sv
// filterbank_scheduler: shares one biquad MAC across all bands and sections,
// summing band outputs into one saturated sample.
module filterbank_scheduler
   import filterbank_pkg::*;
(
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   valid_in,
   input  logic signed [31:0]     sample_in,
   output logic                   ready_out,
   filterbank_scheduler_if.master mac,
   output logic signed [31:0]     sample_out,
   output logic                   valid_out,
   output logic                   busy_out,
   output logic                   overflow_out,
   output logic                   protocol_err_out
);

   sched_state_t state, state_n;

   logic [BAND_W-1:0]        band, band_n;
   logic [SEC_W-1:0]         sec, sec_n;
   logic signed [ACC_W-1:0]  acc, acc_n;
   logic signed [31:0]       x_hold, x_hold_n;
   logic signed [31:0]       x_cur, x_cur_n;
   logic signed [31:0]       out_q, out_n;
   logic                     valid_q, valid_n;
   logic                     perr, perr_n;
   logic                     grace, grace_n;
   logic                     req;
   logic                     load;
   logic                     full;
   logic signed [31:0]       slot_q;

   sample_slot u_slot (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .push     (valid_in),
      .data     (sample_in),
      .pop      (load),
      .full     (full),
      .q        (slot_q),
      .ready    (ready_out),
      .overflow (overflow_out)
   );

   assign load = full && (state == IDLE || state == DONE);

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state   <= IDLE;
         band    <= '0;
         sec     <= '0;
         acc     <= '0;
         x_hold  <= '0;
         x_cur   <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
         perr    <= 1'b0;
         grace   <= 1'b1;
      end else begin
         state   <= state_n;
         band    <= band_n;
         sec     <= sec_n;
         acc     <= acc_n;
         x_hold  <= x_hold_n;
         x_cur   <= x_cur_n;
         out_q   <= out_n;
         valid_q <= valid_n;
         perr    <= perr_n;
         grace   <= grace_n;
      end
   end

   always_comb begin
      state_n  = state;
      band_n   = band;
      sec_n    = sec;
      acc_n    = acc;
      x_hold_n = x_hold;
      x_cur_n  = x_cur;
      out_n    = out_q;
      valid_n  = 1'b0;
      perr_n   = perr;
      grace_n  = grace;
      req      = 1'b0;

      // A result still in flight from an aborted sample is
      // absorbed once after reset, until a new request is taken.
      if (mac.mac_valid_in && state != WAIT) begin
         if (grace)
            grace_n = 1'b0;
         else
            perr_n = 1'b1;
      end

      unique case (state)
         IDLE: ;
         ISSUE: begin
            req = 1'b1;
            if (mac.mac_ready_in) begin
               state_n = WAIT;
               grace_n = 1'b0;
            end
         end
         WAIT: begin
            if (mac.mac_valid_in) begin
               if (sec != SEC_W'(SECTIONS - 1)) begin
                  x_cur_n = mac.mac_result_in;
                  sec_n   = sec + SEC_W'(1);
                  state_n = ISSUE;
               end else begin
                  acc_n = acc + {{(ACC_W-32){mac.mac_result_in[31]}},
                                 mac.mac_result_in};
                  if (band == BAND_W'(FILTERS - 1)) begin
                     state_n = DONE;
                  end else begin
                     band_n  = band + BAND_W'(1);
                     sec_n   = '0;
                     x_cur_n = x_hold;
                     state_n = ISSUE;
                  end
               end
            end
         end
         DONE: begin
            out_n   = sat32(acc);
            valid_n = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      if (load) begin
         x_hold_n = slot_q;
         x_cur_n  = slot_q;
         band_n   = '0;
         sec_n    = '0;
         acc_n    = '0;
         state_n  = ISSUE;
      end
   end

   assign mac.mac_req_out     = req;
   assign mac.mac_band_out    = band;
   assign mac.mac_section_out = sec;
   assign mac.mac_sample_out  = x_cur;

   assign sample_out       = out_q;
   assign valid_out        = valid_q;
   assign busy_out         = (state != IDLE);
   assign protocol_err_out = perr;

endmodule

// File: tb/tb_filterbank_scheduler.sv
// tb_filterbank_scheduler: table, random and hand sequences against a
// stub MAC and a band/section reference sum.
module tb_filterbank_scheduler;
   import filterbank_pkg::*;

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic               clk_in = 1'b0;
   logic               rst_in = 1'b0;
   logic               valid_in = 1'b0;
   logic signed [31:0] sample_in = '0;
   logic               ready_out;
   logic signed [31:0] sample_out;
   logic               valid_out;
   logic               busy_out;
   logic               overflow_out;
   logic               protocol_err_out;

   filterbank_scheduler_if mac_bus();

   filterbank_scheduler dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .valid_in         (valid_in),
      .sample_in        (sample_in),
      .ready_out        (ready_out),
      .mac              (mac_bus),
      .sample_out       (sample_out),
      .valid_out        (valid_out),
      .busy_out         (busy_out),
      .overflow_out     (overflow_out),
      .protocol_err_out (protocol_err_out)
   );

   always #5 clk_in = ~clk_in;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name,
                        input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // External MAC stand-in: y depends on mode, band, section and x
   function automatic logic signed [31:0] mac_fn(
      input int m, input int b, input int s,
      input logic signed [31:0] x);
      case (m)
         0: return x + 1;
         1: return (s == 1) ? 32'sh7fff_ffff : x + 1;
         2: return (s == 1) ? 32'sh8000_0000 : x + 1;
         default: return x + 32'(b * 1000) - 32'(s * 7);
      endcase
   endfunction

   function automatic longint model(input int m,
                                    input logic signed [31:0] x);
      longint acc;
      logic signed [31:0] y;
      acc = 0;
      for (int b = 0; b < FILTERS; b++) begin
         y = x;
         for (int s = 0; s < SECTIONS; s++)
            y = mac_fn(m, b, s, y);
         acc += longint'(y);
      end
      if (acc > SMAX) return SMAX;
      if (acc < SMIN) return SMIN;
      return acc;
   endfunction

   int mode  = 0;
   int lat   = 1;
   int stall = 0;
   bit spur  = 1'b0;
   int req_q[$];

   initial begin : mac_stub
      bit                 pend;
      int                 pend_cnt;
      logic signed [31:0] pend_y;
      bit                 req_seen;
      int                 stall_left;
      bit                 acc_edge;
      int                 rec_b;
      int                 rec_s;
      logic signed [31:0] rec_x;
      pend = 0; pend_cnt = 0; pend_y = '0;
      req_seen = 0; stall_left = 0; acc_edge = 0;
      rec_b = 0; rec_s = 0; rec_x = '0;
      mac_bus.mac_ready_in  = 1'b1;
      mac_bus.mac_valid_in  = 1'b0;
      mac_bus.mac_result_in = '0;
      forever begin
         @(negedge clk_in);
         if (mac_bus.mac_req_out) begin
            if (!req_seen) begin
               req_seen   = 1;
               stall_left = stall;
               rec_b      = int'(mac_bus.mac_band_out);
               rec_s      = int'(mac_bus.mac_section_out);
               rec_x      = mac_bus.mac_sample_out;
            end else begin
               check("stall_hold",
                     {mac_bus.mac_band_out, mac_bus.mac_section_out,
                      mac_bus.mac_sample_out},
                     {BAND_W'(rec_b), SEC_W'(rec_s), rec_x});
            end
            if (stall_left > 0) begin
               mac_bus.mac_ready_in = 1'b0;
               stall_left--;
            end else begin
               mac_bus.mac_ready_in = 1'b1;
            end
         end else begin
            req_seen = 0;
            mac_bus.mac_ready_in = 1'b1;
         end
         acc_edge = mac_bus.mac_req_out && mac_bus.mac_ready_in;
         @(posedge clk_in);
         #1;
         mac_bus.mac_valid_in = 1'b0;
         if (acc_edge) begin
            req_seen = 0;
            pend     = 1;
            pend_cnt = lat;
            pend_y   = mac_fn(mode, rec_b, rec_s, rec_x);
            req_q.push_back(rec_b * 16 + rec_s);
         end
         if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               pend = 0;
               mac_bus.mac_valid_in  = 1'b1;
               mac_bus.mac_result_in = pend_y;
            end
         end else if (spur) begin
            spur = 0;
            mac_bus.mac_valid_in  = 1'b1;
            mac_bus.mac_result_in = 32'sh0001_2345;
         end
      end
   end

   task automatic check_order(input string tag, input int n);
      bit ok;
      ok = 1;
      for (int i = 0; i < req_q.size() && i < n; i++) begin
         if (req_q[i] != ((i % (FILTERS * SECTIONS)) / SECTIONS) * 16
                        + (i % SECTIONS))
            ok = 0;
      end
      check({tag, "_nreq"}, req_q.size(), n);
      check({tag, "_order"}, ok, 1);
   endtask

   task automatic run_sample(input logic signed [31:0] x,
                             input longint exp_out,
                             input int exp_lat,
                             input string tag);
      int n;
      bit seen;
      req_q.delete();
      @(posedge clk_in);
      #1;
      valid_in  = 1'b1;
      sample_in = x;
      @(posedge clk_in);
      #1;
      valid_in = 1'b0;
      n = 0;
      seen = 0;
      while (n < 400 && !seen) begin
         @(posedge clk_in);
         n++;
         #1;
         if (valid_out) seen = 1;
      end
      check({tag, "_seen"}, seen, 1);
      check({tag, "_lat"}, n, exp_lat);
      check({tag, "_out"}, sample_out, exp_out);
      check_order(tag, FILTERS * SECTIONS);
      @(posedge clk_in);
      #1;
      check({tag, "_strobe"}, valid_out, 0);
      check({tag, "_hold"}, sample_out, exp_out);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_sample"}, sample_out, 0);
      check({tag, "_valid"}, valid_out, 0);
      check({tag, "_req"}, mac_bus.mac_req_out, 0);
      check({tag, "_busy"}, busy_out, 0);
      check({tag, "_ovf"}, overflow_out, 0);
      check({tag, "_perr"}, protocol_err_out, 0);
      check({tag, "_ready"}, ready_out, 1);
   endtask

   typedef struct {
      int                 mode;
      int                 lat;
      int                 stall;
      logic signed [31:0] x;
      longint             exp_out;
      int                 exp_lat;
   } vec_t;

   vec_t tbl[6];

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   initial begin : main
      int n;
      int l;
      int st;
      logic signed [31:0] x;

      tbl[0] = '{0, 1, 0, 100, 918, 38};
      tbl[1] = '{1, 1, 0, 100, SMAX, 38};
      tbl[2] = '{2, 1, 0, 100, SMIN, 38};
      tbl[3] = '{0, 1, 3, 100, 918, 92};
      tbl[4] = '{0, 1, 0, -50, -432, 38};
      tbl[5] = '{0, 2, 0, 7, 81, 56};

      repeat (2) @(posedge clk_in);
      #1;
      check_reset_vals("por");
      rst_in = 1'b1;
      repeat (2) @(posedge clk_in);

      for (int i = 0; i < 6; i++) begin
         mode  = tbl[i].mode;
         lat   = tbl[i].lat;
         stall = tbl[i].stall;
         run_sample(tbl[i].x, tbl[i].exp_out, tbl[i].exp_lat,
                    $sformatf("vec%0d", i));
      end

      for (int i = 0; i < 24; i++) begin
         l     = int'($urandom_range(1, 3));
         st    = int'($urandom_range(0, 2));
         x     = $urandom;
         mode  = 3;
         lat   = l;
         stall = st;
         run_sample(x, model(3, x), 2 + FILTERS * SECTIONS * (1 + l + st),
                    $sformatf("rnd%0d", i));
      end
      check("perr_clean", protocol_err_out, 0);
      check("ovf_clean", overflow_out, 0);

      // Second sample queued while busy, third one dropped
      mode = 0; lat = 1; stall = 0;
      req_q.delete();
      @(posedge clk_in);
      #1;
      valid_in = 1'b1; sample_in = 100;
      @(posedge clk_in);
      #1;
      valid_in = 1'b0;
      repeat (4) @(posedge clk_in);
      #1;
      valid_in = 1'b1; sample_in = 200;
      @(posedge clk_in);
      #1;
      valid_in = 1'b0;
      check("ovf_ready", ready_out, 0);
      check("ovf_none_yet", overflow_out, 0);
      valid_in = 1'b1; sample_in = 300;
      @(posedge clk_in);
      #1;
      valid_in = 1'b0;
      check("ovf_flag", overflow_out, 1);
      n = 6;
      while (n < 400 && !valid_out) begin
         @(posedge clk_in);
         n++;
         #1;
      end
      check("ovf_lat1", n, 38);
      check("ovf_out1", sample_out, 918);
      n = 0;
      do begin
         @(posedge clk_in);
         n++;
         #1;
      end while (n < 400 && !valid_out);
      check("ovf_gap", n, 37);
      check("ovf_out2", sample_out, 1818);
      check_order("ovf", 2 * FILTERS * SECTIONS);
      repeat (2) @(posedge clk_in);

      // Reset while band 4 result is in flight
      mode = 0; lat = 3; stall = 0;
      req_q.delete();
      @(posedge clk_in);
      #1;
      valid_in = 1'b1; sample_in = 100;
      @(posedge clk_in);
      #1;
      valid_in = 1'b0;
      n = 0;
      while (n < 400 && req_q.size() < 9) begin
         @(posedge clk_in);
         n++;
         #2;
      end
      check("rst_reach", req_q.size(), 9);
      rst_in = 1'b0;
      #1;
      check_reset_vals("rst");
      @(posedge clk_in);
      #2;
      rst_in = 1'b1;
      repeat (4) @(posedge clk_in);
      #1;
      check("rst_late_perr", protocol_err_out, 0);
      check("rst_late_busy", busy_out, 0);
      check("rst_late_valid", valid_out, 0);
      run_sample(100, 918, 2 + FILTERS * SECTIONS * 4, "post_rst");

      // Unsolicited MAC result while idle
      lat = 1;
      spur = 1'b1;
      repeat (3) @(posedge clk_in);
      #1;
      check("spur_perr", protocol_err_out, 1);
      check("spur_valid", valid_out, 0);
      check("spur_sample", sample_out, 918);
      repeat (5) @(posedge clk_in);
      #1;
      check("spur_sticky", protocol_err_out, 1);
      check("spur_busy", busy_out, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
